// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the write-through L1 data cache.
// Widths are functions so each instance derives them from its own geometry.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WTHRU,
    ST_RESP
  } state_t;

  localparam int ADDR_W         = 32;
  localparam int DEF_LINE_BYTES = 16;

  typedef logic [DEF_LINE_BYTES*8-1:0] line_t;

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int line_bytes, input int sets);
    return ADDR_W - $clog2(line_bytes) - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One way of the cache: valid flops, tag array with combinational lookup,
// and a line data array with byte-masked write and registered read.
module dcache_way_array #(
  parameter int TAG_BITS   = 22,
  parameter int INDEX_W    = 6,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_valid,
  input  logic [INDEX_W-1:0]      lookup_index,
  input  logic [TAG_BITS-1:0]     lookup_tag,
  output logic                    hit,
  output logic                    valid,
  output logic [LINE_BYTES*8-1:0] rd_line,
  input  logic                    wr_en,
  input  logic                    fill,
  input  logic [INDEX_W-1:0]      wr_index,
  input  logic [TAG_BITS-1:0]     wr_tag,
  input  logic [LINE_BYTES-1:0]   wr_mask,
  input  logic [LINE_BYTES*8-1:0] wr_data
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]         valid_reg;
  logic [TAG_BITS-1:0]     tag_mem  [SETS];
  logic [LINE_BYTES*8-1:0] data_mem [SETS];

  assign valid = valid_reg[lookup_index];
  assign hit   = valid && (tag_mem[lookup_index] == lookup_tag);

  // Flush has priority; it never coincides with a fill in practice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (clear_valid) begin
      valid_reg <= '0;
    end else if (wr_en && fill) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && fill) begin
      tag_mem[wr_index] <= wr_tag;
    end
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wr_en && wr_mask[b]) begin
        data_mem[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    rd_line <= data_mem[lookup_index];
  end

endmodule

// File: rtl/data_cache.sv
// Set-associative write-through, no-write-allocate L1 data cache with a
// blocking miss FSM, round-robin replacement per set and deferred flush.
module data_cache
  import dcache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int ID_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             req_address,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [XLEN/8-1:0]       req_write_select,
  input  logic [XLEN-1:0]         req_wr_data,
  input  logic [ID_W-1:0]         req_id,
  input  logic                    flush,
  output logic                    busy,
  output logic                    rsp_done,
  output logic                    rsp_hit,
  output logic [XLEN-1:0]         rsp_rd_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [XLEN/8-1:0]       mem_write_select,
  output logic [XLEN-1:0]         mem_wr_data,
  input  logic [LINE_BYTES*8-1:0] mem_rd_data,
  input  logic                    mem_done
);

  localparam int WORD_BYTES = XLEN / 8;
  localparam int OFFSET_W   = offset_w(LINE_BYTES);
  localparam int INDEX_W    = index_w(SETS);
  localparam int TAG_BITS   = tag_bits(LINE_BYTES, SETS);
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W     = LINE_BYTES * 8;

  state_t state_reg, state_next;

  logic [31:0]         addr_reg;
  logic [ID_W-1:0]     id_reg;
  logic [WORD_BYTES-1:0] strobe_reg;
  logic [XLEN-1:0]     wdata_reg;
  logic                hit_reg;
  logic [WAY_W-1:0]    hit_way_reg;
  logic [WAY_W-1:0]    victim_reg;
  logic                flush_pend_reg;
  logic                hit_pulse_reg;
  logic [XLEN-1:0]     data_hold_reg;
  logic [WAY_W-1:0]    rr_reg [SETS];

  logic [INDEX_W-1:0]  req_index, fill_index, wr_index;
  logic [TAG_BITS-1:0] req_tag;
  logic [WAYS-1:0]     way_hit, way_valid, way_wr_en;
  logic [LINE_W-1:0]   way_q [WAYS];
  logic [WAY_W-1:0]    hit_way, victim;
  logic                any_hit, accept, fill_en, write_hit_en, clear_valid;
  logic [LINE_BYTES-1:0] wr_mask;
  logic [LINE_W-1:0]   wr_data, sel_line;
  logic [XLEN-1:0]     hit_word, fill_word;

  assign req_index  = req_address[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag    = req_address[31 -: TAG_BITS];
  assign fill_index = addr_reg[OFFSET_W+INDEX_W-1:OFFSET_W];

  assign any_hit      = |way_hit;
  assign accept       = (state_reg == ST_IDLE) && !flush_pend_reg && (req_read || req_write);
  assign fill_en      = (state_reg == ST_FILL) && mem_done;
  assign write_hit_en = accept && req_write && any_hit;
  // A flush only takes effect in an IDLE cycle that is not starting a request.
  assign clear_valid  = (state_reg == ST_IDLE) && !accept && (flush || flush_pend_reg);

  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) hit_way = WAY_W'(i);
    end
    victim = rr_reg[req_index];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim = WAY_W'(i);
    end
  end

  // Fill writes the whole line; a store hit merges its word lanes in place.
  assign wr_index = fill_en ? fill_index : req_index;
  assign wr_mask  = fill_en ? '1 : (LINE_BYTES'(req_write_select) << req_address[OFFSET_W-1:0]);
  assign wr_data  = fill_en ? mem_rd_data : {(LINE_BYTES/WORD_BYTES){req_wr_data}};

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_wr_en[gi] = (fill_en && (victim_reg == WAY_W'(gi))) ||
                           (write_hit_en && (hit_way == WAY_W'(gi)));

    dcache_way_array #(
      .TAG_BITS   (TAG_BITS),
      .INDEX_W    (INDEX_W),
      .LINE_BYTES (LINE_BYTES)
    ) u_way (
      .clk          (clk),
      .reset        (reset),
      .clear_valid  (clear_valid),
      .lookup_index (req_index),
      .lookup_tag   (req_tag),
      .hit          (way_hit[gi]),
      .valid        (way_valid[gi]),
      .rd_line      (way_q[gi]),
      .wr_en        (way_wr_en[gi]),
      .fill         (fill_en),
      .wr_index     (wr_index),
      .wr_tag       (addr_reg[31 -: TAG_BITS]),
      .wr_mask      (wr_mask),
      .wr_data      (wr_data)
    );
  end

  assign sel_line  = way_q[hit_way_reg];
  assign hit_word  = sel_line[{addr_reg[OFFSET_W-1:0], 3'b000} +: XLEN];
  assign fill_word = mem_rd_data[{addr_reg[OFFSET_W-1:0], 3'b000} +: XLEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      id_reg         <= '0;
      strobe_reg     <= '0;
      wdata_reg      <= '0;
      hit_reg        <= 1'b0;
      hit_way_reg    <= '0;
      victim_reg     <= '0;
      flush_pend_reg <= 1'b0;
      hit_pulse_reg  <= 1'b0;
      data_hold_reg  <= '0;
      for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
    end else begin
      state_reg     <= state_next;
      hit_pulse_reg <= accept && !req_write && any_hit;
      if (accept) begin
        addr_reg    <= req_address;
        id_reg      <= req_id;
        strobe_reg  <= req_write_select;
        wdata_reg   <= req_wr_data;
        hit_reg     <= any_hit;
        hit_way_reg <= hit_way;
        victim_reg  <= victim;
      end
      // Load data is captured so it holds steady between responses.
      if (hit_pulse_reg) begin
        data_hold_reg <= hit_word;
      end else if (fill_en) begin
        data_hold_reg <= fill_word;
      end
      if (clear_valid) begin
        flush_pend_reg <= 1'b0;
      end else if (flush) begin
        flush_pend_reg <= 1'b1;
      end
      if (fill_en) begin
        rr_reg[fill_index] <= (rr_reg[fill_index] == WAY_W'(WAYS - 1)) ? '0
                                                                        : rr_reg[fill_index] + 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    busy             = (state_reg != ST_IDLE) || flush_pend_reg;
    rsp_done         = hit_pulse_reg;
    rsp_hit          = hit_pulse_reg;
    rsp_rd_data      = hit_pulse_reg ? hit_word : data_hold_reg;
    rsp_id           = id_reg;
    mem_address      = '0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_write_select = '0;
    mem_wr_data      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (req_write)     state_next = ST_WTHRU;
          else if (!any_hit) state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_read    = 1'b1;
        mem_address = {addr_reg[31:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem_done) state_next = ST_RESP;
      end
      ST_WTHRU: begin
        mem_write        = 1'b1;
        mem_address      = addr_reg;
        mem_write_select = strobe_reg;
        mem_wr_data      = wdata_reg;
        if (mem_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_done   = 1'b1;
        rsp_hit    = hit_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomised bench for data_cache: a set/way/pointer model plus a flat reference
// memory predict hits, load data and memory traffic for every request.
module tb_data_cache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_address;
  logic        req_read, req_write;
  logic [3:0]  req_write_select;
  logic [31:0] req_wr_data;
  logic [3:0]  req_id;
  logic        flush;
  logic        busy, rsp_done, rsp_hit;
  logic [31:0] rsp_rd_data;
  logic [3:0]  rsp_id;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_write_select;
  logic [31:0] mem_wr_data;
  line_t       mem_rd_data;
  logic        mem_done;

  data_cache dut (
    .clk(clk), .reset(reset),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_write_select(req_write_select), .req_wr_data(req_wr_data), .req_id(req_id),
    .flush(flush), .busy(busy), .rsp_done(rsp_done), .rsp_hit(rsp_hit),
    .rsp_rd_data(rsp_rd_data), .rsp_id(rsp_id),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_select(mem_write_select), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory is what the DUT wrote through; reference memory is what it should hold.
  logic [31:0] bmem [int unsigned];
  logic [31:0] rmem [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rd_b(input int unsigned wa);
    return bmem.exists(wa) ? bmem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] rd_r(input int unsigned wa);
    return rmem.exists(wa) ? rmem[wa] : init_word(wa);
  endfunction

  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic [3:0]  last_wr_sel;

  initial begin
    int cnt;
    int unsigned base;
    logic [31:0] w;
    cnt = -1;
    mem_done = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (!(mem_read || mem_write)) begin
        cnt = -1;
      end else if (cnt < 0) begin
        cnt = $urandom_range(0, 3);
        if (mem_read) begin
          rd_cnt++;
          last_rd_addr = mem_address;
        end else begin
          wr_cnt++;
          last_wr_addr = mem_address;
          last_wr_sel  = mem_write_select;
          last_wr_data = mem_wr_data;
        end
      end else if (cnt == 0) begin
        mem_done = 1'b1;
        base = mem_address >> 2;
        if (mem_read) begin
          for (int i = 0; i < 4; i++) mem_rd_data[32*i +: 32] = rd_b(base + i);
        end else begin
          w = rd_b(base);
          for (int b = 0; b < 4; b++) if (mem_write_select[b]) w[8*b +: 8] = mem_wr_data[8*b +: 8];
          bmem[base] = w;
        end
        cnt = -1;
      end else begin
        cnt--;
      end
    end
  end

  // Cache model: which tags each set holds and its replacement pointer.
  logic [21:0] m_tag   [64][2];
  bit          m_valid [64][2];
  int          m_rr    [64];

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < 64; s++) for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [3:0] sel,
                        input logic [31:0] d, input logic [3:0] id, input bit flush_mid);
    int s, n, rd0, wr0, v;
    logic [21:0] t;
    bit hit, got_done, flushed;
    int unsigned wa;
    logic [31:0] w, exp_data;
    s  = int'(a[9:4]);
    t  = a[31:10];
    wa = a >> 2;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) if (m_valid[s][k] && m_tag[s][k] == t) hit = 1'b1;
    wait_idle();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_address = a; req_read = !wr; req_write = wr;
    req_write_select = sel; req_wr_data = d; req_id = id;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    n = 1; got_done = 1'b0; flushed = 1'b0;
    while (n <= 60) begin
      if (rsp_done) begin
        got_done = 1'b1;
        break;
      end
      if (flush_mid && n == 1) begin
        flush = 1'b1;
        flushed = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      n++;
    end
    if (wr) begin
      w = rd_r(wa);
      for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
      rmem[wa] = w;
    end else if (!hit) begin
      v = -1;
      for (int k = 1; k >= 0; k--) if (!m_valid[s][k]) v = k;
      if (v < 0) v = m_rr[s];
      m_tag[s][v] = t;
      m_valid[s][v] = 1'b1;
      m_rr[s] = (m_rr[s] + 1) % 2;
    end
    exp_data = rd_r(wa);
    check("rsp_done", got_done, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_hit", rsp_hit, hit);
    if (!wr) check("rd_data", rsp_rd_data, exp_data);
    if (!wr && hit) check("hit_latency", n, 1);
    check("mem_rd_cnt", rd_cnt - rd0, (!wr && !hit));
    check("mem_wr_cnt", wr_cnt - wr0, wr);
    if (!wr && !hit) check("fill_addr", last_rd_addr, {a[31:4], 4'h0});
    if (wr) begin
      check("wr_addr", last_wr_addr, a);
      check("wr_sel", last_wr_sel, sel);
      check("wr_data", last_wr_data, d);
    end
    @(negedge clk);
    check("done_pulse", rsp_done, 0);
    check("busy_post", busy, flushed);
    if (flushed) model_flush();
    $display("REQ %s addr=%08h sel=%h id=%0d hit=%0d data=%08h flush=%0d cycles=%0d",
             wr ? "ST" : "LD", a, sel, id, hit, wr ? d : rsp_rd_data, flushed, n);
  endtask

  task automatic idle_flush();
    wait_idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_nobusy", busy, 0);
    model_flush();
    $display("FLUSH idle");
  endtask

  initial begin
    int unsigned ra;
    bit seen;
    int n;
    reset = 1'b1;
    req_address = '0; req_read = 1'b0; req_write = 1'b0;
    req_write_select = '0; req_wr_data = '0; req_id = '0; flush = 1'b0;
    bmem[32'h400] = 32'hDEAD_BEEF;
    rmem[32'h400] = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", rsp_done, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_rd_data", rsp_rd_data, 0);
    check("rst_id", rsp_id, 0);
    reset = 1'b0;
    @(negedge clk);

    do_req(0, 32'h0000_1000, 4'h0, 32'h0, 4'd3, 0);
    do_req(0, 32'h0000_1000, 4'h0, 32'h0, 4'd5, 0);
    do_req(1, 32'h0000_1000, 4'b0011, 32'h0000_1234, 4'd6, 0);
    do_req(0, 32'h0000_1000, 4'h0, 32'h0, 4'd7, 0);
    check("merge_word", rsp_rd_data, 32'hDEAD_1234);
    do_req(1, 32'h0000_2000, 4'hF, 32'hCAFE_F00D, 4'd8, 0);
    do_req(0, 32'h0000_2000, 4'h0, 32'h0, 4'd9, 0);
    do_req(0, 32'h0000_0040, 4'h0, 32'h0, 4'd1, 0);
    do_req(0, 32'h0000_0440, 4'h0, 32'h0, 4'd2, 0);
    do_req(0, 32'h0000_0840, 4'h0, 32'h0, 4'd3, 0);
    do_req(0, 32'h0000_0C40, 4'h0, 32'h0, 4'd4, 0);
    do_req(0, 32'h0000_0040, 4'h0, 32'h0, 4'd5, 0);
    do_req(0, 32'h0000_3000, 4'h0, 32'h0, 4'd10, 1);
    do_req(0, 32'h0000_3000, 4'h0, 32'h0, 4'd11, 0);
    idle_flush();
    do_req(0, 32'h0000_3000, 4'h0, 32'h0, 4'd12, 0);

    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      do_req($urandom_range(0, 2) == 0, ra, 4'($urandom_range(1, 15)), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) idle_flush();
    end

    wait_idle();
    req_address = 32'h8000_0040; req_write = 1'b1;
    req_write_select = 4'hF; req_wr_data = 32'h1111_2222; req_id = 4'd13;
    @(negedge clk);
    req_write = 1'b0;
    n = 0;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wthru_seen", mem_write, 1);
    reset = 1'b1;
    #1;
    check("abort_mem_write", mem_write, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    $display("RESET mid write-through");
    do_req(0, 32'h0000_1000, 4'h0, 32'h0, 4'd14, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
